// File: rtl/adder_acc_ctrl.sv
// adder_acc_ctrl: sequences ADD/LOAD/CLEAR commands around an external 16-bit adder and latches its sum and flags
module adder_acc_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_cmd,
  input  logic [15:0]        in_data,
  output logic [15:0]        add_in1,
  output logic [15:0]        add_in2,
  input  logic [15:0]        add_sum,
  input  logic               add_carry,
  input  logic               add_parity,
  input  logic               add_overflow,
  input  logic               add_zero,
  input  logic               add_sign,
  output logic [15:0]        acc,
  output logic               flag_carry,
  output logic               flag_parity,
  output logic               flag_overflow,
  output logic               flag_zero,
  output logic               flag_sign,
  output logic               sticky_ov,
  output logic               sticky_carry,
  output logic [COUNT_W-1:0] op_count,
  output logic               out_valid
);
  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic take;
  assign in_ready = state == IDLE;
  assign take = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      add_in1 <= '0;
      add_in2 <= '0;
      op_count <= '0;
      {flag_carry, flag_parity, flag_overflow, flag_zero, flag_sign} <= '0;
      {sticky_ov, sticky_carry, out_valid} <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (take) begin
          case (in_cmd)
            2'b00: begin
              add_in1 <= acc;
              add_in2 <= in_data;
              cnt <= '0;
              state <= SETTLE;
            end
            2'b01: begin
              acc <= in_data;
              out_valid <= 1'b1;
            end
            2'b10: begin
              acc <= '0;
              op_count <= '0;
              {flag_carry, flag_parity, flag_overflow, flag_zero, flag_sign} <= '0;
              {sticky_ov, sticky_carry} <= '0;
              out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          state <= cnt == 4'(SETTLE_CYCLES - 1) ? COMMIT : SETTLE;
        end
        COMMIT: begin
          acc <= add_sum;
          {flag_carry, flag_parity, flag_overflow, flag_zero, flag_sign} <=
            {add_carry, add_parity, add_overflow, add_zero, add_sign};
          sticky_ov <= sticky_ov | add_overflow;
          sticky_carry <= sticky_carry | add_carry;
          op_count <= &op_count ? op_count : op_count + 1'b1;
          out_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_acc_ctrl.sv
// tb_adder_acc_ctrl: directed self-checking bench with a behavioural adder model
module tb_adder_acc_ctrl;
  logic clk, rst, in_valid;
  logic [1:0] in_cmd;
  logic [15:0] in_data;
  logic in_ready, out_valid, flag_carry, flag_parity, flag_overflow, flag_zero, flag_sign, sticky_ov, sticky_carry;
  logic [15:0] add_in1, add_in2, add_sum, acc;
  logic add_carry, add_parity, add_overflow, add_zero, add_sign;
  logic [7:0] op_count;
  logic in_ready2, out_valid2, fc2, fp2, fo2, fz2, fs2, so2, sc2;
  logic [15:0] a2_in1, a2_in2, a2_sum, acc2;
  logic a2_carry, a2_parity, a2_overflow, a2_zero, a2_sign;
  logic [1:0] op_count2;
  int checks = 0;
  int errors = 0;

  assign {add_carry, add_sum} = {1'b0, add_in1} + {1'b0, add_in2};
  assign add_parity = ^add_sum;
  assign add_overflow = (add_in1[15] == add_in2[15]) && (add_sum[15] != add_in1[15]);
  assign add_zero = add_sum == 16'h0;
  assign add_sign = add_sum[15];

  assign {a2_carry, a2_sum} = {1'b0, a2_in1} + {1'b0, a2_in2};
  assign a2_parity = ^a2_sum;
  assign a2_overflow = (a2_in1[15] == a2_in2[15]) && (a2_sum[15] != a2_in1[15]);
  assign a2_zero = a2_sum == 16'h0;
  assign a2_sign = a2_sum[15];

  adder_acc_ctrl #(.SETTLE_CYCLES(2), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_data(in_data),
    .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum), .add_carry(add_carry), .add_parity(add_parity),
    .add_overflow(add_overflow), .add_zero(add_zero), .add_sign(add_sign), .acc(acc),
    .flag_carry(flag_carry), .flag_parity(flag_parity), .flag_overflow(flag_overflow), .flag_zero(flag_zero),
    .flag_sign(flag_sign), .sticky_ov(sticky_ov), .sticky_carry(sticky_carry), .op_count(op_count),
    .out_valid(out_valid)
  );

  adder_acc_ctrl #(.SETTLE_CYCLES(2), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_cmd(in_cmd), .in_data(in_data),
    .add_in1(a2_in1), .add_in2(a2_in2), .add_sum(a2_sum), .add_carry(a2_carry), .add_parity(a2_parity),
    .add_overflow(a2_overflow), .add_zero(a2_zero), .add_sign(a2_sign), .acc(acc2),
    .flag_carry(fc2), .flag_parity(fp2), .flag_overflow(fo2), .flag_zero(fz2),
    .flag_sign(fs2), .sticky_ov(so2), .sticky_carry(sc2), .op_count(op_count2),
    .out_valid(out_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] d);
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_cmd = c;
    in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_add(input logic [15:0] d, input logic [15:0] e);
    logic [15:0] a0;
    a0 = acc;
    send(2'b00, d);
    chk("add_ready_low", in_ready, 0);
    chk("add_in1", add_in1, a0);
    chk("add_in2", add_in2, d);
    repeat (2) begin
      step();
      chk("settle_ready_low", in_ready, 0);
      chk("settle_no_valid", out_valid, 0);
      chk("hold_in1", add_in1, a0);
      chk("hold_in2", add_in2, d);
    end
    step();
    chk("add_acc", acc, e);
    chk("add_valid", out_valid, 1);
    chk("add_ready_back", in_ready, 1);
    step();
    chk("add_valid_pulse", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_cmd = 2'b00;
    in_data = 16'h0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_acc", acc, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", op_count, 0);
    chk("rst_in1", add_in1, 0);
    chk("rst_flags", {flag_carry, flag_parity, flag_overflow, flag_zero, flag_sign, sticky_ov, sticky_carry}, 0);

    send(2'b01, 16'h8FFF);
    chk("load_acc", acc, 16'h8FFF);
    chk("load_valid", out_valid, 1);
    chk("load_count", op_count, 0);
    step();
    chk("load_pulse", out_valid, 0);
    do_add(16'h8000, 16'h0FFF);
    chk("t1_flags", {flag_carry, flag_overflow, flag_sign, flag_zero}, 4'b1100);
    chk("t1_parity", flag_parity, ^16'h0FFF);
    chk("t1_sticky", {sticky_ov, sticky_carry}, 2'b11);
    chk("t1_count", op_count, 1);

    send(2'b01, 16'hFFFE);
    do_add(16'h0002, 16'h0000);
    chk("t2_flags", {flag_carry, flag_overflow, flag_sign, flag_zero}, 4'b1001);
    chk("t2_sticky", {sticky_ov, sticky_carry}, 2'b11);

    send(2'b01, 16'hAAAA);
    do_add(16'h5555, 16'hFFFF);
    chk("t3_flags", {flag_carry, flag_overflow, flag_sign, flag_zero}, 4'b0010);
    chk("t3_count", op_count, 3);

    send(2'b10, 16'h0);
    chk("clr_acc", acc, 0);
    chk("clr_valid", out_valid, 1);
    chk("clr_count", op_count, 0);
    chk("clr_sticky", {sticky_ov, sticky_carry}, 2'b00);
    in_valid = 1'b1;
    in_cmd = 2'b00;
    in_data = 16'h0001;
    step();
    for (int k = 1; k <= 3; k++) begin
      repeat (3) step();
      chk("b2b_acc", acc, 32'(k));
      chk("b2b_valid", out_valid, 1);
      if (k == 3) in_valid = 1'b0;
      step();
      chk("b2b_pulse", out_valid, 0);
    end
    chk("b2b_count", op_count, 3);
    send(2'b10, 16'h0);
    chk("clr2_acc", acc, 0);
    chk("clr2_count", op_count, 0);
    chk("clr2_sticky", {sticky_ov, sticky_carry}, 2'b00);
    step();

    send(2'b01, 16'h0100);
    step();
    send(2'b00, 16'h0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", in_ready, 1);
    chk("abort_acc", acc, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_in", {add_in1, add_in2}, 0);
    repeat (3) begin
      step();
      chk("abort_quiet", out_valid, 0);
      chk("abort_acc_hold", acc, 0);
    end
    do_add(16'h0005, 16'h0005);

    send(2'b11, 16'h1234);
    chk("rsv_acc", acc, 16'h0005);
    chk("rsv_valid", out_valid, 0);
    chk("rsv_ready", in_ready, 1);
    do_add(16'h0001, 16'h0006);
    do_add(16'h0001, 16'h0007);
    chk("sat_pre", op_count2, 3);
    do_add(16'h0001, 16'h0008);
    chk("sat_hold", op_count2, 3);
    chk("count_wide", op_count, 4);
    chk("sat_acc", acc2, 16'h0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_acc_ctrl.md
Name: adder_acc_ctrl

Overview:
Sequential accumulator controller that sits around the 16-bit ripple-carry adder. Upstream, it accepts operand/command words over a valid/ready handshake and drives the adder's in1/in2 from registers. Downstream, it waits a fixed settle time, then latches the adder's sum and flags (carry, parity, overflow, zero, sign) into an accumulator and status register. It also keeps sticky error flags and an operation count for the datapath controller.

Parameters:
SETTLE_CYCLES, 2, clock cycles the adder inputs are held stable before sum/flags are sampled; legal range 1..15.
COUNT_W, 8, width of the ADD operation counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  command/operand word present
in_ready  output  1  block can accept a word; high only in IDLE
in_cmd  input  2  00 ADD, 01 LOAD, 10 CLEAR, 11 reserved
in_data  input  16  operand for ADD/LOAD
add_in1  output  16  registered operand A to adder (accumulator value)
add_in2  output  16  registered operand B to adder (in_data)
add_sum  input  16  adder sum
add_carry  input  1  adder carry-out
add_parity  input  1  adder parity flag
add_overflow  input  1  adder signed overflow
add_zero  input  1  adder zero flag
add_sign  input  1  adder sign flag
acc  output  16  accumulator
flag_carry, flag_parity, flag_overflow, flag_zero, flag_sign  output  1 each  flags of last committed ADD
sticky_ov  output  1  OR of overflow over all ADDs since reset/CLEAR
sticky_carry  output  1  OR of carry over all ADDs since reset/CLEAR
op_count  output  COUNT_W  number of committed ADDs, saturating
out_valid  output  1  one-cycle pulse after each ADD/LOAD/CLEAR commit

Behaviour:
- Reset (rst=1 at edge): state IDLE; acc, add_in1, add_in2, op_count = 0; all flags, sticky bits and out_valid = 0. rst has priority over every other event, including a transaction in SETTLE/COMMIT; the in-flight operation is discarded with no out_valid.
- in_ready = (state==IDLE), decoded from the state register. A transfer occurs on an edge with in_valid & in_ready.
- States: IDLE, SETTLE, COMMIT.
- IDLE, ADD accepted: add_in1<=acc; add_in2<=in_data; cnt<=0; go to SETTLE.
- IDLE, LOAD accepted: acc<=in_data; out_valid<=1; stay in IDLE; flags, sticky bits and op_count are unchanged.
- IDLE, CLEAR accepted: acc, flags, sticky bits and op_count <= 0; out_valid<=1; stay in IDLE.
- IDLE, cmd 11 accepted: consumed with no effect and no out_valid.
- SETTLE: cnt increments each edge. When cnt==SETTLE_CYCLES-1, go to COMMIT. add_in1 and add_in2 must not change while in SETTLE or COMMIT.
- COMMIT, single edge:
  - acc<=add_sum; flag_* <= corresponding add_* inputs.
  - sticky_ov |= add_overflow; sticky_carry |= add_carry.
  - op_count+1, saturating at all-ones.
  - out_valid<=1; go to IDLE.
- Latency: an ADD accepted at edge E0 updates acc at edge E0+SETTLE_CYCLES+1. out_valid is high in the following cycle. in_ready is high in that same cycle, so back-to-back throughput is one ADD per SETTLE_CYCLES+2 cycles.
- out_valid is otherwise 0; it is never asserted for two consecutive cycles by the same operation.
- Arithmetic is modulo 2^16 by the adder; this block performs no arithmetic except cnt and op_count.
- in_valid while in_ready=0 is ignored; the upstream source must hold the word until the transfer occurs.

Test Plan:
- Reset then LOAD 8FFF, ADD 8000 (SETTLE_CYCLES=2) -> acc=0FFF at E0+3; carry=1, overflow=1, sign=0, zero=0; sticky_ov=1; op_count=1; out_valid is a single pulse.
- LOAD FFFE, ADD 0002 -> acc=0000, carry=1, zero=1, overflow=0; sticky_carry=1; in_ready is low for exactly 3 cycles after the accept.
- LOAD AAAA, ADD 5555 -> acc=FFFF, sign=1, carry=0, overflow=0, zero=0; add_in1/add_in2 stay at AAAA/5555 throughout SETTLE.
- Three back-to-back ADD 0001 from acc=0, with in_valid held high -> acc 1,2,3 at 4-cycle spacing; op_count=3; then CLEAR -> acc=0, op_count=0, sticky bits=0.
- rst asserted in the cycle after an ADD accept -> next cycle is IDLE with all outputs 0 and no out_valid; a subsequent ADD 0005 gives acc=0005.
- cmd 11 with data 1234 -> acc unchanged, out_valid stays 0, in_ready stays high; op_count saturation forced at COUNT_W=2 stays at 3 after a 4th ADD.
